// File: rtl/seq_count_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// seq_count_pkg
// Shared definitions for the sequence counter controller:
//   - state_e        : controller states (IDLE, RUN, PAUSE)
//   - DEF_W / DEF_AW : default value width and table index width
//   - RST_LEN        : index of the last entry after reset
//   - rst_entry()    : reset contents of the sequence table {0,3,5,7,2,1,0,0}
// ----------------------------------------------------------------------------
package seq_count_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    localparam int DEF_W  = 3;
    localparam int DEF_AW = 3;

    localparam logic [DEF_AW-1:0] RST_LEN = 3'd5;

    // Reset value of table entry i.
    function automatic logic [DEF_W-1:0] rst_entry(input int unsigned i);
        logic [DEF_W-1:0] v;
        case (i)
            32'd0:   v = 3'd0;
            32'd1:   v = 3'd3;
            32'd2:   v = 3'd5;
            32'd3:   v = 3'd7;
            32'd4:   v = 3'd2;
            32'd5:   v = 3'd1;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/seq_count_ctrl_if.sv
// ----------------------------------------------------------------------------
// seq_count_ctrl_if
// Control/configuration/status bundle of the sequence counter controller.
//   master : drives cfg_we/cfg_addr/cfg_data, len, start, stop, hold, loop
//            (and dir when SEQ_COUNT_CTRL_DIR_EN is defined); observes status
//   slave  : the controller side; drives o, idx, busy, wrap, done
// Optional macro: SEQ_COUNT_CTRL_DIR_EN adds the dir signal.
// ----------------------------------------------------------------------------
interface seq_count_ctrl_if
    import seq_count_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) ();

    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_data;
    logic [AW-1:0] len;
    logic          start;
    logic          stop;
    logic          hold;
    logic          loop;
`ifdef SEQ_COUNT_CTRL_DIR_EN
    logic          dir;
`endif
    logic [W-1:0]  o;
    logic [AW-1:0] idx;
    logic          busy;
    logic          wrap;
    logic          done;

    modport master (
        output cfg_we, cfg_addr, cfg_data, len, start, stop, hold, loop,
`ifdef SEQ_COUNT_CTRL_DIR_EN
        output dir,
`endif
        input  o, idx, busy, wrap, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, len, start, stop, hold, loop,
`ifdef SEQ_COUNT_CTRL_DIR_EN
        input  dir,
`endif
        output o, idx, busy, wrap, done
    );

endinterface

// File: rtl/seq_count_table.sv
// ----------------------------------------------------------------------------
// seq_count_table
// 2**AW x W sequence register file, updated on the falling edge of clk.
//   clr            : synchronous reload of the default table
//   we/waddr/wdata : single write port
//   raddr/rdata    : combinational read port (returns pre-write contents)
// ----------------------------------------------------------------------------
module seq_count_table
    import seq_count_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    // Next table contents: apply the write, if any.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Table storage with default reload on clr.
    always_ff @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= W'(rst_entry(i));
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/seq_count_ctrl.sv
// ----------------------------------------------------------------------------
// seq_count_ctrl
// Steps a W-bit output through a programmable 2**AW entry table with an
// IDLE/RUN/PAUSE state machine; all state changes on the falling clk edge.
//   clk, clr : clock and synchronous active-high reset (table reloads too)
//   ifc      : seq_count_ctrl_if.slave (config write, len/loop/start/stop/
//              hold controls, o/idx/busy/wrap/done status)
// Optional macro: SEQ_COUNT_CTRL_DIR_EN adds ifc.dir; when sampled high at
// start the sequence runs from entry len down to entry 0.
// ----------------------------------------------------------------------------
module seq_count_ctrl
    import seq_count_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic           clk,
    input  logic           clr,
    seq_count_ctrl_if.slave ifc
);

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_RUN   = S_RUN;
    localparam logic [1:0] ST_PAUSE = S_PAUSE;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic [W-1:0]  o_q,     o_d;
    logic [AW-1:0] len_q,   len_d;
    logic          loop_q,  loop_d;
    logic          wrap_q,  wrap_d;
    logic          done_q,  done_d;
    logic          load_s;
    logic          clear_s;
    logic          dir_s;
    logic          start_dir_s;
    logic          tbl_we_s;
    logic [W-1:0]  rdata_s;

`ifdef SEQ_COUNT_CTRL_DIR_EN
    logic dir_q, dir_d;
    assign dir_s       = dir_q;
    assign start_dir_s = ifc.dir;
`else
    assign dir_s       = 1'b0;
    assign start_dir_s = 1'b0;
`endif

    // Configuration writes only land while idle.
    assign tbl_we_s = ifc.cfg_we && (state_q == ST_IDLE);

    // Read address follows the next index so o_d can pick up its entry.
    seq_count_table #(.W(W), .AW(AW)) u_table (
        .clk   (clk),
        .clr   (clr),
        .we    (tbl_we_s),
        .waddr (ifc.cfg_addr),
        .wdata (ifc.cfg_data),
        .raddr (idx_d),
        .rdata (rdata_s)
    );

    // FSM and index next-state: stop > start > hold > step.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        loop_d  = loop_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        load_s  = 1'b0;
        clear_s = 1'b0;
`ifdef SEQ_COUNT_CTRL_DIR_EN
        dir_d   = dir_q;
`endif
        if (ifc.stop) begin
            state_d = ST_IDLE;
            idx_d   = {AW{1'b0}};
            clear_s = 1'b1;
        end else if (ifc.start) begin
            state_d = ST_RUN;
            len_d   = ifc.len;
            loop_d  = ifc.loop;
            idx_d   = start_dir_s ? ifc.len : {AW{1'b0}};
            load_s  = 1'b1;
`ifdef SEQ_COUNT_CTRL_DIR_EN
            dir_d   = ifc.dir;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (ifc.hold) begin
                        state_d = ST_PAUSE;
                    end else if (idx_q == (dir_s ? {AW{1'b0}} : len_q)) begin
                        if (loop_q) begin
                            idx_d  = dir_s ? len_q : {AW{1'b0}};
                            load_s = 1'b1;
                            wrap_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d  = dir_s ? (idx_q - AW'(1)) : (idx_q + AW'(1));
                        load_s = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (!ifc.hold) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = {AW{1'b0}};
                    clear_s = 1'b1;
                end
            endcase
        end
    end

    // Output value next-state: cleared, reloaded from the table, or held.
    always_comb begin
        o_d = o_q;
        if (clear_s) begin
            o_d = {W{1'b0}};
        end else if (load_s) begin
            o_d = rdata_s;
        end else begin
            o_d = o_q;
        end
    end

    // Controller registers.
    always_ff @(negedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            idx_q   <= {AW{1'b0}};
            o_q     <= {W{1'b0}};
            len_q   <= AW'(RST_LEN);
            loop_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_COUNT_CTRL_DIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            o_q     <= o_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
`ifdef SEQ_COUNT_CTRL_DIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign ifc.o    = o_q;
    assign ifc.idx  = idx_q;
    assign ifc.busy = (state_q != ST_IDLE);
    assign ifc.wrap = wrap_q;
    assign ifc.done = done_q;

endmodule

// File: tb/tb_seq_count_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_count_ctrl
// Directed-vector bench for seq_count_ctrl. The DUT acts on the falling
// edge; inputs change and outputs are sampled just after the rising edge.
// ----------------------------------------------------------------------------
module tb_seq_count_ctrl;

    logic clk = 1'b0;
    logic clr;
    int   n_vec = 0;
    int   n_bad = 0;

    seq_count_ctrl_if ifc ();

    seq_count_ctrl dut (
        .clk (clk),
        .clr (clr),
        .ifc (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int o, input int idx,
                           input int busy, input int wrap, input int done);
        chk({tag, ".o"},    int'(ifc.o),    o);
        chk({tag, ".idx"},  int'(ifc.idx),  idx);
        chk({tag, ".busy"}, int'(ifc.busy), busy);
        chk({tag, ".wrap"}, int'(ifc.wrap), wrap);
        chk({tag, ".done"}, int'(ifc.done), done);
    endtask

    // One active (falling) edge, then move to the rising edge to sample/drive.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len, input int loop);
        ifc.len   = 3'(len);
        ifc.loop  = 1'(loop);
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic do_stop();
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
    endtask

    task automatic do_write(input int addr, input int data);
        ifc.cfg_we   = 1'b1;
        ifc.cfg_addr = 3'(addr);
        ifc.cfg_data = 3'(data);
        tick();
        ifc.cfg_we   = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int seq_o [8];
        int seq_w [8];
        seq_o = '{0, 3, 5, 7, 2, 1, 0, 3};
        seq_w = '{0, 0, 0, 0, 0, 0, 1, 0};

        clr = 1'b1;
        ifc.cfg_we = 1'b0; ifc.cfg_addr = 3'd0; ifc.cfg_data = 3'd0;
        ifc.len = 3'd0; ifc.start = 1'b0; ifc.stop = 1'b0;
        ifc.hold = 1'b0; ifc.loop = 1'b0;
`ifdef SEQ_COUNT_CTRL_DIR_EN
        ifc.dir = 1'b0;
`endif
        do_clr();
        chk_all("reset", 0, 0, 0, 0, 0);

        // Default table, looping.
        do_start(5, 1);
        chk_all("loop0", seq_o[0], 0, 1, seq_w[0], 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("loop%0d.o", i), int'(ifc.o), seq_o[i]);
            chk($sformatf("loop%0d.wrap", i), int'(ifc.wrap), seq_w[i]);
        end
        do_stop();
        chk_all("stop1", 0, 0, 0, 0, 0);

        // One-shot over a rewritten short table.
        do_write(0, 6);
        do_write(1, 4);
        do_write(2, 2);
        do_start(2, 0);
        chk_all("os0", 6, 0, 1, 0, 0);
        tick(); chk_all("os1", 4, 1, 1, 0, 0);
        tick(); chk_all("os2", 2, 2, 1, 0, 0);
        tick(); chk_all("os_done", 2, 2, 0, 0, 1);
        tick(); chk_all("os_after", 2, 2, 0, 0, 0);

        // clr restores table; then hold for 3 edges at o=5.
        do_clr();
        do_start(5, 1);
        tick(); tick();
        chk_all("pre_hold", 5, 2, 1, 0, 0);
        ifc.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("hold%0d", i), 5, 2, 1, 0, 0);
        end
        ifc.hold = 1'b0;
        tick(); chk_all("release", 5, 2, 1, 0, 0);
        tick(); chk_all("resume1", 7, 3, 1, 0, 0);
        tick(); chk_all("resume2", 2, 4, 1, 0, 0);

        // Restart while running at idx 4.
        do_start(5, 1);
        chk_all("restart0", 0, 0, 1, 0, 0);
        tick(); chk_all("restart1", 3, 1, 1, 0, 0);

        // Write while busy is dropped.
        do_write(1, 4);
        chk_all("busy_wr", 5, 2, 1, 0, 0);
        tick(); tick(); tick();
        tick(); chk_all("wrap_pass", 0, 0, 1, 1, 0);
        tick(); chk_all("idx1_kept", 3, 1, 1, 0, 0);
        tick();
        do_stop();
        chk_all("stop_mid", 0, 0, 0, 0, 0);

        // clr mid-run after a table rewrite.
        do_write(0, 7);
        do_start(5, 1);
        chk("rw.o", int'(ifc.o), 7);
        tick(); chk("rw_step.o", int'(ifc.o), 3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_all("clr_mid", 0, 0, 0, 0, 0);
        do_start(5, 1);
        chk("restored.o", int'(ifc.o), 0);
        tick(); chk("restored1.o", int'(ifc.o), 3);
        do_stop();

        // len=0 loop: wrap every edge.
        do_start(0, 1);
        chk_all("l0loop0", 0, 0, 1, 0, 0);
        tick(); chk_all("l0loop1", 0, 0, 1, 1, 0);
        tick(); chk_all("l0loop2", 0, 0, 1, 1, 0);
        do_stop();
        chk_all("l0stop", 0, 0, 0, 0, 0);

        // len=0 one-shot: done on the edge after start.
        do_start(0, 0);
        chk_all("l0os0", 0, 0, 1, 0, 0);
        tick(); chk_all("l0os1", 0, 0, 0, 0, 1);
        tick(); chk_all("l0os2", 0, 0, 0, 0, 0);

        // Write and start on the same edge: o takes the old entry 0.
        ifc.cfg_we = 1'b1; ifc.cfg_addr = 3'd0; ifc.cfg_data = 3'd6;
        do_start(5, 0);
        ifc.cfg_we = 1'b0;
        chk_all("wr_start", 0, 0, 1, 0, 0);
        tick(); chk("wr_start1.o", int'(ifc.o), 3);
        do_stop();
        // len/loop changes mid-run are ignored.
        do_start(1, 0);
        chk("new0.o", int'(ifc.o), 6);
        ifc.len = 3'd5; ifc.loop = 1'b1;
        tick(); chk_all("ign1", 3, 1, 1, 0, 0);
        tick(); chk_all("ign_done", 3, 1, 0, 0, 1);

`ifdef SEQ_COUNT_CTRL_DIR_EN
        // Reverse stepping over the default table.
        do_clr();
        ifc.dir = 1'b1;
        do_start(5, 1);
        ifc.dir = 1'b0;
        begin
            int dseq [7];
            int didx [7];
            int dwr  [7];
            dseq = '{1, 2, 7, 5, 3, 0, 1};
            didx = '{5, 4, 3, 2, 1, 0, 5};
            dwr  = '{0, 0, 0, 0, 0, 0, 1};
            for (int i = 0; i < 7; i++) begin
                if (i != 0) tick();
                chk_all($sformatf("dir%0d", i), dseq[i], didx[i], 1, dwr[i], 0);
            end
        end
        do_stop();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
